result_writeback: RTL and testbench

- Receives one filtered pixel per cycle from the 3x3 core, one output row at a time (MAX_COL-2 pixels per row).
- Stores each row in a two-bank ping-pong row buffer.
- Drains each completed row to the memory controller over a valid/ready byte stream with linear write addresses.
- Reports row and frame completion to the controller, and asserts backpressure when both banks are full.

---
 rtl/postproc_pkg.sv | 20 ++
 rtl/row_bank_ram.sv | 24 ++
 rtl/result_writeback.sv | 145 ++++++++++++++
 tb/tb_result_writeback.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/postproc_pkg.sv
// Shared types and size helpers for the post-processing write-back path.
package postproc_pkg;

    typedef enum logic [0:0] {
        StIdle,
        StDrain
    } wb_state_e;

    typedef logic [9:0] cnt10_t;

    // The 3x3 window loses one pixel on each border, so the output is two smaller per axis.
    function automatic int unsigned out_col_f(int unsigned max_col);
        return max_col - 2;
    endfunction

    function automatic int unsigned out_row_f(int unsigned max_row);
        return max_row - 2;
    endfunction

endpackage

// File: rtl/row_bank_ram.sv
// One row bank: a synchronous write port and an asynchronous read port.
module row_bank_ram #(
    parameter int unsigned DEPTH = 538,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/result_writeback.sv
// Collects filtered rows into a ping-pong row buffer and streams each finished row out
// as bytes with linear addresses, flagging row/frame completion and backpressure.
module result_writeback
    import postproc_pkg::*;
#(
    parameter int unsigned MAX_ROW = 540,
    parameter int unsigned MAX_COL = 540,
    parameter int unsigned ADDR_W  = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              core_en_i,
    input  logic [7:0]        core_data_i,
    output logic              wr_valid_o,
    input  logic              wr_ready_i,
    output logic [7:0]        wr_data_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic              row_done_o,
    output logic              frame_done_o,
    output logic              buf_full_o,
    output logic              overflow_o,
    output logic [9:0]        cnt_in_col_o,
    output logic [9:0]        cnt_out_col_o
);

    localparam int unsigned OUT_COL  = out_col_f(MAX_COL);
    localparam int unsigned OUT_ROW  = out_row_f(MAX_ROW);
    localparam int unsigned RAM_AW   = $clog2(OUT_COL);
    localparam cnt10_t      LAST_COL = cnt10_t'(OUT_COL - 1);
    localparam cnt10_t      LAST_ROW = cnt10_t'(OUT_ROW - 1);

    wb_state_e         state, state_next;
    cnt10_t            in_col, in_col_next;
    cnt10_t            out_col, out_col_next;
    cnt10_t            out_row, out_row_next;
    logic [ADDR_W-1:0] addr, addr_next;
    logic [1:0]        full, full_next;
    logic              wr_bank, wr_bank_next;
    logic              rd_bank, rd_bank_next;
    logic              overflow, overflow_next;

    logic              buf_full, accept, fill_last, xfer, row_end, frame_end;
    logic [7:0]        rdata0, rdata1, rd_byte;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= StIdle;
            in_col   <= '0;
            out_col  <= '0;
            out_row  <= '0;
            addr     <= '0;
            full     <= '0;
            wr_bank  <= 1'b0;
            rd_bank  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state    <= state_next;
            in_col   <= in_col_next;
            out_col  <= out_col_next;
            out_row  <= out_row_next;
            addr     <= addr_next;
            full     <= full_next;
            wr_bank  <= wr_bank_next;
            rd_bank  <= rd_bank_next;
            overflow <= overflow_next;
        end
    end

    always_comb begin
        buf_full  = full[0] & full[1];
        accept    = core_en_i & ~buf_full;
        fill_last = accept && (in_col == LAST_COL);
        xfer      = (state == StDrain) && wr_ready_i;
        row_end   = xfer && (out_col == LAST_COL);
        frame_end = row_end && (out_row == LAST_ROW);

        state_next    = state;
        in_col_next   = in_col;
        out_col_next  = out_col;
        out_row_next  = out_row;
        addr_next     = addr;
        full_next     = full;
        wr_bank_next  = wr_bank;
        rd_bank_next  = rd_bank;
        overflow_next = overflow | (core_en_i & buf_full);

        if (accept) begin
            in_col_next = fill_last ? '0 : in_col + 10'd1;
        end
        // Fill and drain always address opposite banks, so both flag updates can coexist.
        if (fill_last) begin
            full_next[wr_bank] = 1'b1;
            wr_bank_next       = ~wr_bank;
        end
        if (xfer) begin
            out_col_next = row_end ? '0 : out_col + 10'd1;
            addr_next    = frame_end ? '0 : addr + ADDR_W'(1);
        end
        if (row_end) begin
            full_next[rd_bank] = 1'b0;
            rd_bank_next       = ~rd_bank;
            out_row_next       = frame_end ? '0 : out_row + 10'd1;
        end

        unique case (state)
            StIdle:  if (full[rd_bank]) state_next = StDrain;
            StDrain: if (row_end) state_next = StIdle;
            default: state_next = StIdle;
        endcase
    end

    row_bank_ram #(
        .DEPTH (OUT_COL)
    ) u_bank0 (
        .clk   (clk),
        .we    (accept & ~wr_bank),
        .waddr (in_col[RAM_AW-1:0]),
        .wdata (core_data_i),
        .raddr (out_col[RAM_AW-1:0]),
        .rdata (rdata0)
    );

    row_bank_ram #(
        .DEPTH (OUT_COL)
    ) u_bank1 (
        .clk   (clk),
        .we    (accept & wr_bank),
        .waddr (in_col[RAM_AW-1:0]),
        .wdata (core_data_i),
        .raddr (out_col[RAM_AW-1:0]),
        .rdata (rdata1)
    );

    assign rd_byte       = rd_bank ? rdata1 : rdata0;
    assign wr_valid_o    = (state == StDrain);
    assign wr_data_o     = wr_valid_o ? rd_byte : 8'd0;
    assign wr_addr_o     = wr_valid_o ? addr : '0;
    assign row_done_o    = row_end;
    assign frame_done_o  = frame_end;
    assign buf_full_o    = buf_full;
    assign overflow_o    = overflow;
    assign cnt_in_col_o  = in_col;
    assign cnt_out_col_o = out_col;

endmodule

// File: tb/tb_result_writeback.sv
// Directed bench for result_writeback with a 6x4 output frame.
module tb_result_writeback;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        core_en_i;
    logic [7:0]  core_data_i;
    logic        wr_valid_o;
    logic        wr_ready_i;
    logic [7:0]  wr_data_o;
    logic [19:0] wr_addr_o;
    logic        row_done_o;
    logic        frame_done_o;
    logic        buf_full_o;
    logic        overflow_o;
    logic [9:0]  cnt_in_col_o;
    logic [9:0]  cnt_out_col_o;

    int passed = 0;
    int total  = 0;

    result_writeback #(
        .MAX_ROW (6),
        .MAX_COL (8),
        .ADDR_W  (20)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .core_en_i     (core_en_i),
        .core_data_i   (core_data_i),
        .wr_valid_o    (wr_valid_o),
        .wr_ready_i    (wr_ready_i),
        .wr_data_o     (wr_data_o),
        .wr_addr_o     (wr_addr_o),
        .row_done_o    (row_done_o),
        .frame_done_o  (frame_done_o),
        .buf_full_o    (buf_full_o),
        .overflow_o    (overflow_o),
        .cnt_in_col_o  (cnt_in_col_o),
        .cnt_out_col_o (cnt_out_col_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        core_en_i   = 1'b0;
        core_data_i = 8'd0;
        wr_ready_i  = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic push(input int v);
        core_en_i   = 1'b1;
        core_data_i = 8'(v);
        tick();
        core_en_i = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valid"}, 32'(wr_valid_o), 0);
        check({tag, "_data"}, 32'(wr_data_o), 0);
        check({tag, "_addr"}, 32'(wr_addr_o), 0);
        check({tag, "_row_done"}, 32'(row_done_o), 0);
        check({tag, "_frame_done"}, 32'(frame_done_o), 0);
        check({tag, "_buf_full"}, 32'(buf_full_o), 0);
        check({tag, "_overflow"}, 32'(overflow_o), 0);
        check({tag, "_in_col"}, 32'(cnt_in_col_o), 0);
        check({tag, "_out_col"}, 32'(cnt_out_col_o), 0);
    endtask

    // Accepts n bytes d0.. at addresses a0..; with tog, ready alternates 1,0,1,0 over valid cycles.
    task automatic expect_stream(input string tag, input int n, input int d0, input int a0,
                                 input bit tog);
        int k   = 0;
        int cyc = 0;
        bit rdy = 1'b1;
        while (k < n && cyc < 100) begin
            wr_ready_i = rdy;
            #1;
            if (wr_valid_o) begin
                check({tag, "_data"}, 32'(wr_data_o), 32'(d0 + k));
                check({tag, "_addr"}, 32'(wr_addr_o), 32'(a0 + k));
                check({tag, "_row_done"}, 32'(row_done_o), 32'(rdy && ((a0 + k) % 6 == 5)));
                check({tag, "_frame_done"}, 32'(frame_done_o), 32'(rdy && (a0 + k == 23)));
                if (rdy) k++;
                if (tog) rdy = ~rdy;
            end
            tick();
            cyc++;
        end
        check({tag, "_xfer_count"}, 32'(k), 32'(n));
    endtask

    initial begin
        do_reset();
        check_idle_outputs("reset");

        // 1: one row, latency and plain streaming
        wr_ready_i = 1'b1;
        for (int i = 0; i < 6; i++) push(10 + i);
        #1;
        check("t1_valid_n1", 32'(wr_valid_o), 0);
        check("t1_data_idle", 32'(wr_data_o), 0);
        check("t1_addr_idle", 32'(wr_addr_o), 0);
        check("t1_in_col_wrap", 32'(cnt_in_col_o), 0);
        tick();
        check("t1_valid_n2", 32'(wr_valid_o), 1);
        expect_stream("t1", 6, 10, 0, 1'b0);
        #1;
        check("t1_valid_after", 32'(wr_valid_o), 0);

        // 2: same row with ready toggling
        do_reset();
        for (int i = 0; i < 6; i++) push(10 + i);
        expect_stream("t2", 6, 10, 0, 1'b1);
        wr_ready_i = 1'b1;
        tick();
        check("t2_no_extra", 32'(wr_valid_o), 0);

        // 3: fill both banks, overflow, then drain
        do_reset();
        for (int i = 0; i < 12; i++) push(20 + i);
        #1;
        check("t3_buf_full", 32'(buf_full_o), 1);
        check("t3_no_ovf_yet", 32'(overflow_o), 0);
        push(99);
        check("t3_overflow", 32'(overflow_o), 1);
        check("t3_in_col_hold", 32'(cnt_in_col_o), 0);
        expect_stream("t3a", 6, 20, 0, 1'b0);
        check("t3_full_drop", 32'(buf_full_o), 0);
        expect_stream("t3b", 6, 26, 6, 1'b0);
        tick();
        tick();
        check("t3_no_third_row", 32'(wr_valid_o), 0);
        check("t3_overflow_sticky", 32'(overflow_o), 1);

        // 5: reset during the third transfer of a row (continues at address 12)
        for (int i = 0; i < 6; i++) push(50 + i);
        wr_ready_i = 1'b0;
        tick();
        check("t5_valid", 32'(wr_valid_o), 1);
        wr_ready_i = 1'b1;
        #1;
        check("t5_x0_data", 32'(wr_data_o), 50);
        check("t5_x0_addr", 32'(wr_addr_o), 12);
        tick();
        check("t5_x1_data", 32'(wr_data_o), 51);
        check("t5_x1_addr", 32'(wr_addr_o), 13);
        tick();
        rst_n = 1'b0;
        tick();
        check_idle_outputs("t5_rst");
        rst_n = 1'b1;
        tick();
        check("t5_no_partial", 32'(wr_valid_o), 0);
        for (int i = 0; i < 6; i++) push(60 + i);
        expect_stream("t5", 6, 60, 0, 1'b0);
        check("t5_overflow_clear", 32'(overflow_o), 0);

        // 4: full frame, frame_done on address 23, then wrap to address 0
        do_reset();
        wr_ready_i = 1'b1;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 6; c++) push(100 + 6 * r + c);
            expect_stream("t4", 6, 100 + 6 * r, 6 * r, 1'b0);
        end
        for (int c = 0; c < 6; c++) push(200 + c);
        expect_stream("t4_wrap", 6, 200, 0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
